// File: rtl/skein_search_pkg.sv
// Shared widths, sentinel values and result record for the Skein search datapath.
package skein_search_pkg;

   localparam int BITS_OFF_W = 10;
   localparam int NONCE_W    = 256;
   localparam int MAX_CORE_W = 8;

   localparam logic [BITS_OFF_W-1:0] BITS_OFF_WORST = {BITS_OFF_W{1'b1}};

   typedef struct packed {
      logic [BITS_OFF_W-1:0] bits_off;
      logic [NONCE_W-1:0]    nonce;
      logic [MAX_CORE_W-1:0] core;
   } best_result_t;

   // A single lane still needs a one-bit index so ports never collapse to zero width.
   function automatic int coreWidth(input int numCores);
      return (numCores > 1) ? $clog2(numCores) : 1;
   endfunction

endpackage

// File: rtl/best_select_tree.sv
// Combinational minimum search over all lanes; returns the winning value and its lane index.
module best_select_tree
   import skein_search_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int BITS_W    = BITS_OFF_W,
   parameter int CORE_W    = coreWidth(NUM_CORES)
) (
   input  logic [NUM_CORES*BITS_W-1:0] bits_i,
   output logic [BITS_W-1:0]           minBits_o,
   output logic [CORE_W-1:0]           minIdx_o
);

   logic [BITS_W-1:0] minBits;
   logic [CORE_W-1:0] minIdx;

   // Strict less-than while scanning upward keeps the lowest lane on ties.
   always_comb begin
      minBits = bits_i[BITS_W-1:0];
      minIdx  = '0;
      for (int k = 1; k < NUM_CORES; k++) begin
         if (bits_i[k*BITS_W +: BITS_W] < minBits) begin
            minBits = bits_i[k*BITS_W +: BITS_W];
            minIdx  = CORE_W'(k);
         end
      end
   end

   assign minBits_o = minBits;
   assign minIdx_o  = minIdx;

endmodule

// File: rtl/multi_core_best_tracker.sv
// Three-stage merge of per-lane Skein results into a running best, with target flag,
// hash counter and a valid/ready improvement report.
module multi_core_best_tracker
   import skein_search_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int NONCE_W   = skein_search_pkg::NONCE_W,
   parameter int BITS_W    = skein_search_pkg::BITS_OFF_W,
   parameter int COUNT_W   = 48,
   parameter int CORE_W    = coreWidth(NUM_CORES)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic [BITS_W-1:0]            target_bits_i,
   input  logic [NUM_CORES-1:0]         valid_i,
   input  logic [NUM_CORES*BITS_W-1:0]  bits_off_i,
   input  logic [NUM_CORES*NONCE_W-1:0] nonce_i,
   output logic [BITS_W-1:0]            best_bits_off_o,
   output logic [NONCE_W-1:0]           best_nonce_o,
   output logic [CORE_W-1:0]            best_core_o,
   output logic                         found_o,
   output logic                         report_valid_o,
   input  logic                         report_ready_i,
   output logic [BITS_W-1:0]            report_bits_off_o,
   output logic [NONCE_W-1:0]           report_nonce_o,
   output logic [CORE_W-1:0]            report_core_o,
   output logic                         report_overrun_o,
   output logic [COUNT_W-1:0]           hash_count_o
);

   localparam logic [BITS_W-1:0] WORST = {BITS_W{1'b1}};

   logic [NUM_CORES-1:0]         aValid_q;
   logic [NUM_CORES*BITS_W-1:0]  aBits_q, aBits_d;
   logic [NUM_CORES*NONCE_W-1:0] aNonce_q;

   logic [BITS_W-1:0]  selBits;
   logic [CORE_W-1:0]  selIdx;
   logic [NONCE_W-1:0] selNonce;

   logic               bValid_q;
   logic [BITS_W-1:0]  bBits_q;
   logic [NONCE_W-1:0] bNonce_q;
   logic [CORE_W-1:0]  bCore_q;
   logic [COUNT_W-1:0] count_q, count_d;

   logic [BITS_W-1:0]  best_q;
   logic [NONCE_W-1:0] bestNonce_q;
   logic [CORE_W-1:0]  bestCore_q;
   logic               found_q, found_d;

   logic               repValid_q, repValid_d;
   logic               repOverrun_q, repOverrun_d;
   logic [BITS_W-1:0]  repBits_q;
   logic [NONCE_W-1:0] repNonce_q;
   logic [CORE_W-1:0]  repCore_q;

   logic               update;

   // Idle lanes carry the worst score so they can never win the minimum search.
   always_comb begin
      aBits_d = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         aBits_d[k*BITS_W +: BITS_W] = valid_i[k] ? bits_off_i[k*BITS_W +: BITS_W] : WORST;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         aValid_q <= '0;
         aBits_q  <= {NUM_CORES{WORST}};
         aNonce_q <= '0;
      end else if (clear_i) begin
         aValid_q <= '0;
         aBits_q  <= {NUM_CORES{WORST}};
      end else begin
         aValid_q <= valid_i;
         aBits_q  <= aBits_d;
         aNonce_q <= nonce_i;
      end
   end

   best_select_tree #(
      .NUM_CORES (NUM_CORES),
      .BITS_W    (BITS_W),
      .CORE_W    (CORE_W)
   ) selectTree (
      .bits_i    (aBits_q),
      .minBits_o (selBits),
      .minIdx_o  (selIdx)
   );

   assign selNonce = aNonce_q[selIdx*NONCE_W +: NONCE_W];
   assign count_d  = count_q + COUNT_W'($countones(aValid_q));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bValid_q <= 1'b0;
         bBits_q  <= WORST;
         bNonce_q <= '0;
         bCore_q  <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         bValid_q <= 1'b0;
         bBits_q  <= WORST;
         count_q  <= '0;
      end else begin
         bValid_q <= |aValid_q;
         bBits_q  <= selBits;
         bNonce_q <= selNonce;
         bCore_q  <= selIdx;
         count_q  <= count_d;
      end
   end

   // Only a strictly better candidate replaces the best, so the first-found result holds ties.
   assign update = bValid_q && (bBits_q < best_q);

   always_comb begin
      found_d      = found_q;
      repValid_d   = repValid_q;
      repOverrun_d = repOverrun_q;
      if (update) begin
         repValid_d = 1'b1;
         if (bBits_q <= target_bits_i) begin
            found_d = 1'b1;
         end
         if (repValid_q && !report_ready_i) begin
            repOverrun_d = 1'b1;
         end
      end else if (repValid_q && report_ready_i) begin
         repValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         best_q       <= WORST;
         bestNonce_q  <= '0;
         bestCore_q   <= '0;
         found_q      <= 1'b0;
         repValid_q   <= 1'b0;
         repOverrun_q <= 1'b0;
         repBits_q    <= '0;
         repNonce_q   <= '0;
         repCore_q    <= '0;
      end else if (clear_i) begin
         best_q       <= WORST;
         bestNonce_q  <= '0;
         bestCore_q   <= '0;
         found_q      <= 1'b0;
         repValid_q   <= 1'b0;
         repOverrun_q <= 1'b0;
         repBits_q    <= '0;
         repNonce_q   <= '0;
         repCore_q    <= '0;
      end else begin
         found_q      <= found_d;
         repValid_q   <= repValid_d;
         repOverrun_q <= repOverrun_d;
         if (update) begin
            best_q      <= bBits_q;
            bestNonce_q <= bNonce_q;
            bestCore_q  <= bCore_q;
            repBits_q   <= bBits_q;
            repNonce_q  <= bNonce_q;
            repCore_q   <= bCore_q;
         end
      end
   end

   assign best_bits_off_o   = best_q;
   assign best_nonce_o      = bestNonce_q;
   assign best_core_o       = bestCore_q;
   assign found_o           = found_q;
   assign report_valid_o    = repValid_q;
   assign report_bits_off_o = repBits_q;
   assign report_nonce_o    = repNonce_q;
   assign report_core_o     = repCore_q;
   assign report_overrun_o  = repOverrun_q;
   assign hash_count_o      = count_q;

endmodule

// File: tb/tb_multi_core_best_tracker.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a batch-level behavioural model.
module tb_multi_core_best_tracker;

   localparam int NC = 4;
   localparam int NW = 256;
   localparam int BW = 10;
   localparam int CW = 2;

   logic            clk = 1'b0;
   logic            rst_i = 1'b1;
   logic            clear_i = 1'b0;
   logic [BW-1:0]   target_bits_i = '0;
   logic [NC-1:0]   valid_i = '0;
   logic [NC*BW-1:0] bits_off_i = '0;
   logic [NC*NW-1:0] nonce_i = '0;
   logic            report_ready_i = 1'b0;

   logic [BW-1:0]   best_bits_off_o;
   logic [NW-1:0]   best_nonce_o;
   logic [CW-1:0]   best_core_o;
   logic            found_o;
   logic            report_valid_o;
   logic [BW-1:0]   report_bits_off_o;
   logic [NW-1:0]   report_nonce_o;
   logic [CW-1:0]   report_core_o;
   logic            report_overrun_o;
   logic [47:0]     hash_count_o;

   logic [BW-1:0]   sBest;
   logic [NW-1:0]   sNonce;
   logic [CW-1:0]   sCore;
   logic            sFound, sRv, sOv;
   logic [BW-1:0]   sRBits;
   logic [NW-1:0]   sRNonce;
   logic [CW-1:0]   sRCore;
   logic [3:0]      sCount;

   always #5 clk = ~clk;

   multi_core_best_tracker dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .target_bits_i(target_bits_i),
      .valid_i(valid_i), .bits_off_i(bits_off_i), .nonce_i(nonce_i),
      .best_bits_off_o(best_bits_off_o), .best_nonce_o(best_nonce_o), .best_core_o(best_core_o),
      .found_o(found_o), .report_valid_o(report_valid_o), .report_ready_i(report_ready_i),
      .report_bits_off_o(report_bits_off_o), .report_nonce_o(report_nonce_o),
      .report_core_o(report_core_o), .report_overrun_o(report_overrun_o),
      .hash_count_o(hash_count_o)
   );

   multi_core_best_tracker #(.COUNT_W(4)) dutSmall (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .target_bits_i(target_bits_i),
      .valid_i(valid_i), .bits_off_i(bits_off_i), .nonce_i(nonce_i),
      .best_bits_off_o(sBest), .best_nonce_o(sNonce), .best_core_o(sCore),
      .found_o(sFound), .report_valid_o(sRv), .report_ready_i(report_ready_i),
      .report_bits_off_o(sRBits), .report_nonce_o(sRNonce),
      .report_core_o(sRCore), .report_overrun_o(sOv),
      .hash_count_o(sCount)
   );

   typedef struct {
      bit            v;
      logic [BW-1:0] bits;
      logic [NW-1:0] nonce;
      logic [CW-1:0] core;
      int            cnt;
   } batch_t;

   batch_t        p1, p2;
   logic [BW-1:0] mBest;
   logic [NW-1:0] mNonce;
   logic [CW-1:0] mCore;
   bit            mFound, mRv, mOv;
   logic [BW-1:0] mRBits;
   logic [NW-1:0] mRNonce;
   logic [CW-1:0] mRCore;
   logic [47:0]   mCount;

   int  checks = 0;
   int  errors = 0;
   bit  cmpOn = 1'b0;

   localparam logic [NW-1:0] NONCE_A = {8{32'hAAAA_0001}};
   localparam logic [NW-1:0] NONCE_B = {8{32'hBBBB_0002}};

   task automatic check(input string name, input logic [NW-1:0] got, input logic [NW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic resetModel();
      p1 = '{v: 1'b0, bits: '1, nonce: '0, core: '0, cnt: 0};
      p2 = p1;
      mBest = '1; mNonce = '0; mCore = '0;
      mFound = 1'b0; mRv = 1'b0; mOv = 1'b0;
      mRBits = '0; mRNonce = '0; mRCore = '0;
      mCount = '0;
   endtask

   // Best valid lane of one input cycle; the lowest lane keeps ties.
   function automatic batch_t makeBatch();
      batch_t b;
      b = '{v: 1'b0, bits: '1, nonce: '0, core: '0, cnt: 0};
      for (int k = 0; k < NC; k++) begin
         if (valid_i[k]) begin
            b.cnt++;
            if (!b.v || bits_off_i[k*BW +: BW] < b.bits) begin
               b.bits  = bits_off_i[k*BW +: BW];
               b.nonce = nonce_i[k*NW +: NW];
               b.core  = CW'(k);
            end
            b.v = 1'b1;
         end
      end
      return b;
   endfunction

   // Advances the model by one clock edge using the inputs currently driven.
   task automatic modelStep();
      if (clear_i) begin
         resetModel();
      end else begin
         if (p2.v && p2.bits < mBest) begin
            mBest = p2.bits; mNonce = p2.nonce; mCore = p2.core;
            if (p2.bits <= target_bits_i) mFound = 1'b1;
            if (mRv && !report_ready_i) mOv = 1'b1;
            mRv = 1'b1;
            mRBits = p2.bits; mRNonce = p2.nonce; mRCore = p2.core;
         end else if (mRv && report_ready_i) begin
            mRv = 1'b0;
         end
         mCount = mCount + 48'(p1.cnt);
         p2 = p1;
         p1 = makeBatch();
      end
   endtask

   task automatic checkOutput();
      check("best_bits", best_bits_off_o, mBest);
      check("best_nonce", best_nonce_o, mNonce);
      check("best_core", best_core_o, mCore);
      check("found", found_o, mFound);
      check("report_valid", report_valid_o, mRv);
      if (mRv) begin
         check("report_bits", report_bits_off_o, mRBits);
         check("report_nonce", report_nonce_o, mRNonce);
         check("report_core", report_core_o, mRCore);
      end
      check("overrun", report_overrun_o, mOv);
      check("hash_count", hash_count_o, mCount);
      check("hash_count_w4", sCount, mCount[3:0]);
   endtask

   always @(negedge clk) begin
      if (cmpOn && !rst_i) checkOutput();
   end

   task automatic applyStimulus();
      modelStep();
      @(negedge clk);
      #1;
   endtask

   task automatic idleLanes();
      valid_i = '0;
      for (int k = 0; k < NC; k++) begin
         bits_off_i[k*BW +: BW] = BW'($urandom_range(0, 1023));
         nonce_i[k*NW +: NW] = {8{$urandom()}};
      end
   endtask

   task automatic setLane(input int k, input logic [BW-1:0] b, input logic [NW-1:0] n);
      valid_i[k] = 1'b1;
      bits_off_i[k*BW +: BW] = b;
      nonce_i[k*NW +: NW] = n;
   endtask

   task automatic randomCycles(input int n);
      for (int c = 0; c < n; c++) begin
         idleLanes();
         for (int k = 0; k < NC; k++) begin
            if ($urandom_range(0, 3) == 0) setLane(k, BW'($urandom_range(0, 1023)), {8{$urandom()}});
         end
         report_ready_i = ($urandom_range(0, 1) == 1);
         clear_i = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 40) == 0) target_bits_i = BW'($urandom_range(0, 1023));
         applyStimulus();
      end
      clear_i = 1'b0;
   endtask

   initial begin
      resetModel();
      idleLanes();
      repeat (2) @(negedge clk);
      #1;
      rst_i = 1'b0;
      cmpOn = 1'b1;

      check("reset_best", best_bits_off_o, 10'h3FF);
      check("reset_found", found_o, 1'b0);
      check("reset_rv", report_valid_o, 1'b0);
      check("reset_count", hash_count_o, 48'd0);

      // Two lanes in one cycle: lane3 wins.
      report_ready_i = 1'b1;
      setLane(1, 10'd400, NONCE_A);
      setLane(3, 10'd390, NONCE_B);
      applyStimulus();
      idleLanes();
      applyStimulus();
      applyStimulus();
      check("two_lane_bits", best_bits_off_o, 10'd390);
      check("two_lane_nonce", best_nonce_o, NONCE_B);
      check("two_lane_core", best_core_o, 2'd3);
      check("two_lane_rv", report_valid_o, 1'b1);

      // Ties: lowest lane wins, later equal result is ignored.
      setLane(0, 10'd380, NONCE_A);
      setLane(2, 10'd380, NONCE_B);
      applyStimulus();
      idleLanes();
      repeat (2) applyStimulus();
      check("tie_core", best_core_o, 2'd0);
      check("tie_bits", best_bits_off_o, 10'd380);
      setLane(1, 10'd380, NONCE_B);
      applyStimulus();
      idleLanes();
      repeat (2) applyStimulus();
      check("tie_later_core", best_core_o, 2'd0);
      check("tie_later_rv", report_valid_o, 1'b0);

      // Overrun while the host is stalled.
      report_ready_i = 1'b0;
      setLane(0, 10'd370, NONCE_A);
      applyStimulus();
      idleLanes();
      setLane(1, 10'd360, NONCE_B);
      applyStimulus();
      idleLanes();
      repeat (2) applyStimulus();
      check("ovr_rbits", report_bits_off_o, 10'd360);
      check("ovr_flag", report_overrun_o, 1'b1);
      check("ovr_rv", report_valid_o, 1'b1);
      report_ready_i = 1'b1;
      applyStimulus();
      report_ready_i = 1'b0;
      check("ovr_drain_rv", report_valid_o, 1'b0);

      // Target hit, then clear with a better result still in flight.
      target_bits_i = 10'd350;
      setLane(2, 10'd350, NONCE_A);
      applyStimulus();
      idleLanes();
      repeat (2) applyStimulus();
      check("target_found", found_o, 1'b1);
      check("target_bits", best_bits_off_o, 10'd350);
      setLane(0, 10'd300, NONCE_B);
      applyStimulus();
      idleLanes();
      applyStimulus();
      clear_i = 1'b1;
      applyStimulus();
      clear_i = 1'b0;
      repeat (2) applyStimulus();
      check("clear_best", best_bits_off_o, 10'h3FF);
      check("clear_found", found_o, 1'b0);
      check("clear_rv", report_valid_o, 1'b0);
      check("clear_ovr", report_overrun_o, 1'b0);
      check("clear_count", hash_count_o, 48'd0);

      // Counter: 10 cycles of all four lanes.
      for (int c = 0; c < 10; c++) begin
         for (int k = 0; k < NC; k++) setLane(k, BW'($urandom_range(0, 1023)), {8{$urandom()}});
         applyStimulus();
      end
      idleLanes();
      repeat (2) applyStimulus();
      check("count_40", hash_count_o, 48'd40);
      check("count_w4_wrap", sCount, 4'd8);

      randomCycles(1500);

      // Asynchronous reset in the middle of traffic.
      for (int k = 0; k < NC; k++) setLane(k, BW'($urandom_range(0, 200)), {8{$urandom()}});
      applyStimulus();
      rst_i = 1'b1;
      resetModel();
      #1;
      check("async_best", best_bits_off_o, 10'h3FF);
      check("async_count", hash_count_o, 48'd0);
      check("async_rv", report_valid_o, 1'b0);
      check("async_found", found_o, 1'b0);
      @(negedge clk);
      #1;
      rst_i = 1'b0;
      idleLanes();

      randomCycles(500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
